// File: rtl/agu_queue_pkg.sv
// agu_queue_pkg: shared constants and the per-entry strobe bundle of the AGU issue queue
package agu_queue_pkg;
  localparam int TAG_W = 6;
  localparam int DEFAULT_DEPTH = 4;
  typedef struct packed {
    logic we;
    logic updt_cmn;
    logic updt_op1;
    logic op1_from_cdb;
    logic updt_op2;
    logic op2_from_cdb;
    logic src_sel;
  } agu_entry_ctrl_t;
endpackage

// File: rtl/agu_cdb_match.sv
// agu_cdb_match: qualified compare of one stored/dispatched tag against the CDB tag
module agu_cdb_match import agu_queue_pkg::*; #(
  parameter int W = TAG_W
) (
  input  logic         i_en,
  input  logic [W-1:0] i_tag,
  input  logic [W-1:0] i_cdb_tag,
  output logic         o_match
);
  assign o_match = i_en & (i_tag == i_cdb_tag);
endmodule

// File: rtl/agu_queue_ctrl.sv
// agu_queue_ctrl: strobe sequencer, occupancy and issue request for the in-order AGU shift queue.
// Build option AGU_QUEUE_STALL_CNT_EN adds a saturating head-stall counter on o_stall_cnt.
module agu_queue_ctrl #(
  parameter int DEPTH = agu_queue_pkg::DEFAULT_DEPTH,
  parameter int TAG_W = agu_queue_pkg::TAG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_dispatch_valid,
  input  logic [TAG_W-1:0]             i_dispatch_op1_tag,
  input  logic [TAG_W-1:0]             i_dispatch_op2_tag,
  input  logic                         i_dispatch_op1_valid,
  input  logic                         i_dispatch_op2_valid,
  output logic                         o_dispatch_ready,
  input  logic                         i_cdb_valid,
  input  logic [TAG_W-1:0]             i_cdb_tag,
  input  logic [DEPTH-1:0]             i_entry_valid,
  input  logic [DEPTH-1:0]             i_entry_ready,
  input  logic [DEPTH*TAG_W-1:0]       i_entry_op1_tag,
  input  logic [DEPTH*TAG_W-1:0]       i_entry_op2_tag,
  input  logic [DEPTH-1:0]             i_entry_op1_valid,
  input  logic [DEPTH-1:0]             i_entry_op2_valid,
  output logic [DEPTH-1:0]             o_entry_we,
  output logic [DEPTH-1:0]             o_entry_updt_cmn,
  output logic [DEPTH-1:0]             o_entry_updt_op1,
  output logic [DEPTH-1:0]             o_entry_updt_op2,
  output logic [DEPTH-1:0]             o_entry_op1_from_cdb,
  output logic [DEPTH-1:0]             o_entry_op2_from_cdb,
  output logic [DEPTH-1:0]             o_entry_src_sel,
  output logic                         o_issue_req,
  input  logic                         i_issue_grant,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [15:0]                  o_stall_cnt
);
  import agu_queue_pkg::*;
  localparam int CW = $clog2(DEPTH+1);
  logic [CW-1:0] r_count, w_wa;
  logic w_accept, w_fire, w_dm1, w_dm2, w_unused;
  logic [DEPTH-1:0] w_m1, w_m2, w_m1_up, w_m2_up;
  agu_entry_ctrl_t w_ctl [DEPTH];
  assign o_dispatch_ready = r_count != CW'(DEPTH);
  assign w_accept = i_dispatch_valid & o_dispatch_ready;
  assign o_issue_req = i_entry_valid[0] & i_entry_ready[0];
  assign w_fire = o_issue_req & i_issue_grant;
  assign w_wa = w_fire ? r_count - CW'(1) : r_count;
  assign w_unused = ^i_entry_ready[DEPTH-1:1];
  // a shifting entry takes its upper neighbour's wakeup; the top one sees an empty neighbour
  assign w_m1_up = {1'b0, w_m1[DEPTH-1:1]};
  assign w_m2_up = {1'b0, w_m2[DEPTH-1:1]};
  agu_cdb_match #(.W(TAG_W)) u_dm1 (
    .i_en(i_cdb_valid & ~i_dispatch_op1_valid), .i_tag(i_dispatch_op1_tag),
    .i_cdb_tag(i_cdb_tag), .o_match(w_dm1));
  agu_cdb_match #(.W(TAG_W)) u_dm2 (
    .i_en(i_cdb_valid & ~i_dispatch_op2_valid), .i_tag(i_dispatch_op2_tag),
    .i_cdb_tag(i_cdb_tag), .o_match(w_dm2));
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    agu_cdb_match #(.W(TAG_W)) u_m1 (
      .i_en(i_cdb_valid & i_entry_valid[g] & ~i_entry_op1_valid[g]),
      .i_tag(i_entry_op1_tag[g*TAG_W +: TAG_W]), .i_cdb_tag(i_cdb_tag), .o_match(w_m1[g]));
    agu_cdb_match #(.W(TAG_W)) u_m2 (
      .i_en(i_cdb_valid & i_entry_valid[g] & ~i_entry_op2_valid[g]),
      .i_tag(i_entry_op2_tag[g*TAG_W +: TAG_W]), .i_cdb_tag(i_cdb_tag), .o_match(w_m2[g]));
    assign o_entry_we[g]           = w_ctl[g].we;
    assign o_entry_updt_cmn[g]     = w_ctl[g].updt_cmn;
    assign o_entry_updt_op1[g]     = w_ctl[g].updt_op1;
    assign o_entry_updt_op2[g]     = w_ctl[g].updt_op2;
    assign o_entry_op1_from_cdb[g] = w_ctl[g].op1_from_cdb;
    assign o_entry_op2_from_cdb[g] = w_ctl[g].op2_from_cdb;
    assign o_entry_src_sel[g]      = w_ctl[g].src_sel;
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ctl[i] = '0;
      if (w_fire)
        w_ctl[i] = '{we: 1'b1, updt_cmn: 1'b1, updt_op1: 1'b1, op1_from_cdb: w_m1_up[i],
                     updt_op2: 1'b1, op2_from_cdb: w_m2_up[i], src_sel: 1'b0};
      else if (w_m1[i] | w_m2[i])
        w_ctl[i] = '{we: 1'b1, updt_cmn: 1'b0, updt_op1: w_m1[i], op1_from_cdb: w_m1[i],
                     updt_op2: w_m2[i], op2_from_cdb: w_m2[i], src_sel: 1'b0};
      if (w_accept && w_wa == CW'(i))
        w_ctl[i] = '{we: 1'b1, updt_cmn: 1'b1, updt_op1: 1'b1, op1_from_cdb: w_dm1,
                     updt_op2: 1'b1, op2_from_cdb: w_dm2, src_sel: 1'b1};
      if (i_flush)
        w_ctl[i] = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else r_count <= i_flush ? '0 : r_count + CW'(w_accept) - CW'(w_fire);
  end
  assign o_count = r_count;
`ifdef AGU_QUEUE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stall_cnt <= '0;
    else if (i_entry_valid[0] & ~w_fire & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_agu_queue_ctrl.sv
// tb_agu_queue_ctrl: randomized and directed bench for agu_queue_ctrl against a queue-level model
module tb_agu_queue_ctrl;
  localparam int DEPTH = 4;
  localparam int TW = 6;
  localparam int CW = $clog2(DEPTH+1);
  typedef struct {
    logic [TW-1:0] t1;
    logic [TW-1:0] t2;
    logic v1;
    logic v2;
  } ent_t;
  ent_t q[$];
  int stall_m;
  int n_checks = 0;
  int n_fail = 0;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0, dv = 0, dv1 = 0, dv2 = 0, cdb_valid = 0, grant = 0;
  logic [TW-1:0] dt1 = '0, dt2 = '0, cdb_tag = '0;
  logic [DEPTH-1:0] e_valid = '0, e_ready = '0, e_v1 = '0, e_v2 = '0;
  logic [DEPTH*TW-1:0] e_t1 = '0, e_t2 = '0;
  logic d_ready, issue_req;
  logic [DEPTH-1:0] we, cmn, u1, u2, f1, f2, src;
  logic [CW-1:0] count;
  logic [15:0] stall_cnt;
  always #5 clk = ~clk;
  agu_queue_ctrl #(.DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_dispatch_valid(dv), .i_dispatch_op1_tag(dt1), .i_dispatch_op2_tag(dt2),
    .i_dispatch_op1_valid(dv1), .i_dispatch_op2_valid(dv2), .o_dispatch_ready(d_ready),
    .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag),
    .i_entry_valid(e_valid), .i_entry_ready(e_ready),
    .i_entry_op1_tag(e_t1), .i_entry_op2_tag(e_t2),
    .i_entry_op1_valid(e_v1), .i_entry_op2_valid(e_v2),
    .o_entry_we(we), .o_entry_updt_cmn(cmn), .o_entry_updt_op1(u1), .o_entry_updt_op2(u2),
    .o_entry_op1_from_cdb(f1), .o_entry_op2_from_cdb(f2), .o_entry_src_sel(src),
    .o_issue_req(issue_req), .i_issue_grant(grant),
    .o_count(count), .o_stall_cnt(stall_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input logic d, input logic [TW-1:0] a, input logic av,
                       input logic [TW-1:0] b, input logic bv, input logic cv,
                       input logic [TW-1:0] ct, input logic g, input logic f);
    dv = d; dt1 = a; dv1 = av; dt2 = b; dv2 = bv;
    cdb_valid = cv; cdb_tag = ct; grant = g; flush = f;
  endtask
  task automatic present_entries();
    for (int i = 0; i < DEPTH; i++) begin
      if (i < q.size()) begin
        e_valid[i] = 1'b1; e_v1[i] = q[i].v1; e_v2[i] = q[i].v2;
        e_ready[i] = q[i].v1 & q[i].v2;
        e_t1[i*TW +: TW] = q[i].t1; e_t2[i*TW +: TW] = q[i].t2;
      end else begin
        e_valid[i] = 1'b0; e_v1[i] = 1'b0; e_v2[i] = 1'b0; e_ready[i] = 1'b0;
        e_t1[i*TW +: TW] = '0; e_t2[i*TW +: TW] = '0;
      end
    end
  endtask
  // one clock: present model state, check outputs mid-cycle, then advance the model at the edge
  task automatic step();
    int n, wa;
    logic acc, fire, dm1, dm2;
    logic [DEPTH:0] m1, m2;
    logic [DEPTH-1:0] x_we, x_cmn, x_u1, x_u2, x_f1, x_f2, x_src;
    ent_t e;
    present_entries();
    #1;
    n = q.size();
    acc = dv && n != DEPTH;
    fire = n > 0 && q[0].v1 && q[0].v2 && grant;
    wa = fire ? n - 1 : n;
    m1 = '0; m2 = '0;
    for (int i = 0; i < n; i++) begin
      m1[i] = cdb_valid && !q[i].v1 && q[i].t1 == cdb_tag;
      m2[i] = cdb_valid && !q[i].v2 && q[i].t2 == cdb_tag;
    end
    dm1 = cdb_valid && !dv1 && dt1 == cdb_tag;
    dm2 = cdb_valid && !dv2 && dt2 == cdb_tag;
    x_we = '0; x_cmn = '0; x_u1 = '0; x_u2 = '0; x_f1 = '0; x_f2 = '0; x_src = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) continue;
      if (acc && i == wa) begin
        x_we[i] = 1; x_cmn[i] = 1; x_u1[i] = 1; x_u2[i] = 1; x_src[i] = 1;
        x_f1[i] = dm1; x_f2[i] = dm2;
      end else if (fire) begin
        x_we[i] = 1; x_cmn[i] = 1; x_u1[i] = 1; x_u2[i] = 1;
        x_f1[i] = m1[i+1]; x_f2[i] = m2[i+1];
      end else begin
        x_we[i] = m1[i] | m2[i]; x_u1[i] = m1[i]; x_f1[i] = m1[i]; x_u2[i] = m2[i]; x_f2[i] = m2[i];
      end
    end
    check("count", 32'(count), 32'(n));
    check("dispatch_ready", 32'(d_ready), 32'(n != DEPTH));
    check("issue_req", 32'(issue_req), 32'(n > 0 && q[0].v1 && q[0].v2));
    check("we", 32'(we), 32'(x_we));
    check("updt_cmn", 32'(cmn), 32'(x_cmn));
    check("updt_op1", 32'(u1), 32'(x_u1));
    check("updt_op2", 32'(u2), 32'(x_u2));
    check("op1_from_cdb", 32'(f1), 32'(x_f1));
    check("op2_from_cdb", 32'(f2), 32'(x_f2));
    check("src_sel", 32'(src), 32'(x_src));
`ifdef AGU_QUEUE_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
`else
    check("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(posedge clk);
    if (!rst) begin
      if (n > 0 && !fire && stall_m != 65535) stall_m++;
      if (flush) q.delete();
      else begin
        for (int i = 0; i < n; i++) begin
          if (cdb_valid && q[i].t1 == cdb_tag) q[i].v1 = 1'b1;
          if (cdb_valid && q[i].t2 == cdb_tag) q[i].v2 = 1'b1;
        end
        if (fire) void'(q.pop_front());
        if (acc) begin
          e.t1 = dt1; e.t2 = dt2; e.v1 = dv1 | dm1; e.v2 = dv2 | dm2;
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask
  initial begin
    stall_m = 0;
    @(negedge clk);
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_ready", 32'(d_ready), 32'd1);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_we", 32'(we), 32'd0);
    @(negedge clk);
    step();
    rst = 0;
    // fill to DEPTH with ready ops, then hold
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 6'(i), 1, 6'(i), 1, 0, '0, 0, 0);
      step();
    end
    drive(0, '0, 0, '0, 0, 0, '0, 0, 0);
    step();
    // full queue: dispatch refused while head issues and everything shifts
    drive(1, 6'h2a, 1, 6'h2b, 1, 0, '0, 1, 0);
    step();
    drive(0, '0, 0, '0, 0, 0, '0, 0, 0);
    step();
    drive(0, '0, 0, '0, 0, 0, '0, 0, 1);
    step();
    // entry 2 waits on op1 tag 15 and wakes without a fire
    drive(1, 6'h01, 1, 6'h01, 1, 0, '0, 0, 0); step();
    drive(1, 6'h02, 1, 6'h02, 1, 0, '0, 0, 0); step();
    drive(1, 6'h15, 0, 6'h03, 1, 0, '0, 0, 0); step();
    drive(0, '0, 0, '0, 0, 1, 6'h15, 0, 0); step();
    drive(0, '0, 0, '0, 0, 0, '0, 0, 1); step();
    // entry 1 wakes while head fires; tag also matches both operands of that entry
    drive(1, 6'h01, 1, 6'h01, 1, 0, '0, 0, 0); step();
    drive(1, 6'h15, 0, 6'h15, 0, 0, '0, 0, 0); step();
    drive(1, 6'h20, 1, 6'h07, 0, 1, 6'h15, 1, 0); step();
    // dispatch whose op2 is being broadcast right now
    drive(1, 6'h00, 1, 6'h07, 0, 1, 6'h07, 0, 0); step();
    drive(0, '0, 0, '0, 0, 0, '0, 0, 1); step();
    // stalled head at count 3, flush, then asynchronous reset
    drive(1, 6'h30, 0, 6'h01, 1, 0, '0, 0, 0); step();
    drive(1, 6'h02, 1, 6'h02, 1, 0, '0, 0, 0); step();
    drive(1, 6'h03, 1, 6'h03, 1, 0, '0, 1, 0); step();
    drive(0, '0, 0, '0, 0, 0, '0, 1, 0); step(); step();
    drive(0, '0, 0, '0, 0, 0, '0, 0, 1); step();
    drive(1, 6'h30, 0, 6'h01, 1, 0, '0, 0, 0); step();
    drive(0, '0, 0, '0, 0, 0, '0, 0, 0); step(); step();
    #2 rst = 1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_stall", 32'(stall_cnt), 32'd0);
    q.delete();
    stall_m = 0;
    @(negedge clk);
    step();
    rst = 0;
    // randomized traffic with small tag space so wakeups are frequent
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 9) < 7, 6'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            6'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 6'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/agu_queue_ctrl.md
Name: agu_queue_ctrl

Overview:
- Control sequencer for the AGU issue queue: DEPTH reservation entries organised as an in-order shift queue (entry 0 = head, oldest).
- Generates every per-entry write/update strobe: we, updt_cmn_block, updt_op1, updt_op1_from_cdb, updt_op2, updt_op2_from_cdb, plus the source select.
- Tracks occupancy, snoops the CDB tag for operand wakeup, and requests issue of the head entry to the AGU.
- Sits between the dispatch stage and the AGU. Holds no operand data.

Parameters:
DEPTH, 4, number of queue entries (2..16)
TAG_W, 6, CDB/ROB tag width

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  synchronous pipeline flush
dispatch_valid  in  1  new AGU op offered
dispatch_op1_tag / dispatch_op2_tag  in  TAG_W each  source tags of new op
dispatch_op1_valid / dispatch_op2_valid  in  1 each  source data already valid
dispatch_ready  out  1  queue can accept this cycle
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB broadcast tag
entry_valid  in  DEPTH  reg_valid_out of each entry
entry_ready  in  DEPTH  ready of each entry
entry_op1_tag / entry_op2_tag  in  DEPTH*TAG_W  stored tags (entry i at [i*TAG_W +: TAG_W])
entry_op1_valid / entry_op2_valid  in  DEPTH  stored data-valid bits
entry_we, entry_updt_cmn, entry_updt_op1, entry_updt_op2  out  DEPTH each  per-entry strobes
entry_op1_from_cdb / entry_op2_from_cdb  out  DEPTH each  per-entry CDB data select
entry_src_sel  out  DEPTH  0 = load from upper neighbour (top entry's upper input is tied to 0), 1 = load from dispatch bus
issue_req  out  1  head is valid and ready
issue_grant  in  1  AGU accepts head
count  out  $clog2(DEPTH+1)  occupied entries
stall_cnt  out  16  head-stall cycles (optional feature)

Behaviour:
- Reset: clk single clock; rst asynchronous active-high. Reset values: count=0, stall_cnt=0. dispatch_ready=1. All strobes 0.
- dispatch_ready = (count != DEPTH). It is a function of the count register only. A full queue does not accept in the same cycle as an issue.
- accept = dispatch_valid & dispatch_ready.
- issue_req = entry_valid[0] & entry_ready[0].
- fire = issue_req & issue_grant.
- count_next = count + accept - fire.
- Wakeup matching (per entry, per operand): matchN[i] = cdb_valid & entry_valid[i] & !entry_opN_valid[i] & (entry_opN_tag[i]==cdb_tag).
- Dispatch operand matching: dmatchN = cdb_valid & !dispatch_opN_valid & (dispatch_opN_tag==cdb_tag).
- Write address: wa = fire ? count-1 : count.
- Cycle with fire (shift):
  - Every entry i gets we=cmn=op1=op2=1 and src_sel=0.
  - opN_from_cdb[i] = matchN[i+1]; the top entry uses 0.
  - If accept, entry wa overrides: src_sel=1, opN_from_cdb=dmatchN.
- Cycle without fire:
  - If accept: entry wa gets we=cmn=op1=op2=1, src_sel=1, opN_from_cdb=dmatchN.
  - Every other entry with match1|match2 gets we=1 and cmn=0. updt_opN=opN_from_cdb=matchN.
  - All remaining strobes are 0.
- Wakeup latency: a CDB match sets the entry's ready register at the next edge. issue_req can rise at the earliest 1 cycle after the CDB broadcast.
- flush (synchronous, wins over everything): count_next=0 and all strobes forced 0. The entries clear via their own flush input. dispatch_ready=1 the next cycle.
- Invariant (bench assertion): count equals the number of set entry_valid bits, and those bits are contiguous from 0.
- Boundaries:
  - fire with count=1 and accept: the new op lands in entry 0.
  - CDB tag matching both operands of one entry: both updated.
  - CDB matching an entry that is shifting: data is captured into the destination entry.

Optional Feature:
- Macro AGU_QUEUE_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 each cycle with entry_valid[0] & !fire. It saturates at 16'hFFFF, is cleared only by rst, and is unaffected by flush.
- Undefined: stall_cnt tied to 0 and no counter flops.

Decomposition:
- Package agu_queue_pkg holds TAG_W, DEFAULT_DEPTH, and a packed struct agu_entry_ctrl_t {we, updt_cmn, updt_op1, op1_from_cdb, updt_op2, op2_from_cdb, src_sel}.
- One sub-module, agu_cdb_match: tag compare plus valid qualify, instantiated 2*DEPTH+2 times.

Test Plan:
- Reset, then 4 dispatches with both operands valid (DEPTH=4) -> count 1,2,3,4; dispatch_ready=0 at count 4; issue_req=1 once entry_ready[0]=1.
- Full queue, dispatch_valid=1 and issue_grant=1 in the same cycle -> dispatch not accepted; all entries shift; count 4->3; dispatch_ready=1 the next cycle.
- Entry 2 waiting on op1 tag 6'h15, cdb_valid with cdb_tag=6'h15 and no fire -> entry_we[2]=1, entry_updt_op1[2]=1, entry_op1_from_cdb[2]=1, entry_updt_cmn[2]=0.
- Same CDB match on entry 1 while head fires -> entry_op1_from_cdb[0]=1 with full update of entry 0.
- Dispatch with op2 tag 6'h07 invalid while CDB broadcasts 6'h07 -> entry wa gets src_sel=1 and op2_from_cdb=1.
- Count 3, flush asserted, then rst asserted mid-stall -> count=0 after the flush edge; stall_cnt (macro on) holds across flush and clears asynchronously on rst.
